// File: rtl/seg7_pkg.sv
// Shared types and the BCD-to-segment decode for the 3-digit scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        SLOT_ONES = 2'd0,
        SLOT_TENS = 2'd1,
        SLOT_HUND = 2'd2
    } slot_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // seg[6:0] = {a,b,c,d,e,f,g}; codes 10-15 are dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic slot_e slot_succ(input slot_e s);
        slot_e n;
        case (s)
            SLOT_ONES: n = SLOT_TENS;
            SLOT_TENS: n = SLOT_HUND;
            default:   n = SLOT_ONES;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Digit-slot sequencer: CLK_DIV cycles per slot, ONES -> TENS -> HUND -> ONES.
module seg7_refresh_timer
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output slot_e            slot,
    output logic [CNT_W-1:0] cnt,
    output logic             frame_wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    slot_e            slot_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             slot_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= SLOT_ONES;
            cnt  <= '0;
        end else begin
            slot <= slot_nxt;
            cnt  <= cnt_nxt;
        end
    end

    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        cnt_nxt    = slot_end ? '0 : cnt + CNT_W'(1);
        slot_nxt   = slot_end ? slot_succ(slot) : slot;
        frame_wrap = slot_end && (slot == SLOT_HUND);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 3-digit 7-segment driver with a one-entry shadow register
// that is committed to the display only at frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int GAP     = 2,
    parameter int LZB     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       ovf,
    output logic       ready,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] dig_en,
    output logic       frame_done
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    slot_e            slot;
    logic [CNT_W-1:0] cnt;
    logic             frame_wrap;

    logic [3:0] pend_h, pend_t, pend_o;
    logic       pend_ovf, pend_full;
    logic [3:0] disp_h, disp_t, disp_o;
    logic       disp_ovf;

    slot_e            la_slot;
    logic [CNT_W-1:0] la_cnt;
    logic             la_active, hund_zero, blank, show;
    logic [3:0]       digit;
    logic [2:0]       onehot;
    logic [6:0]       seg_d;
    logic [2:0]       dig_en_d;
    logic             dp_d;

    seg7_refresh_timer #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .slot       (slot),
        .cnt        (cnt),
        .frame_wrap (frame_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_h    <= '0;
            pend_t    <= '0;
            pend_o    <= '0;
            pend_ovf  <= 1'b0;
            pend_full <= 1'b0;
            disp_h    <= '0;
            disp_t    <= '0;
            disp_o    <= '0;
            disp_ovf  <= 1'b0;
        end else if (frame_wrap && pend_full) begin
            disp_h    <= pend_h;
            disp_t    <= pend_t;
            disp_o    <= pend_o;
            disp_ovf  <= pend_ovf;
            pend_full <= 1'b0;
        end else if (load && !pend_full) begin
            pend_h    <= hundreds;
            pend_t    <= tens;
            pend_o    <= ones;
            pend_ovf  <= ovf;
            pend_full <= 1'b1;
        end
    end

    assign ready = ~pend_full;

    // Output registers are loaded from the slot/cnt the timer is about to
    // enter, so the visible outputs line up with the current slot/cnt.
    always_comb begin
        la_cnt    = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        la_slot   = (cnt == CNT_LAST) ? slot_succ(slot) : slot;
        la_active = (int'(la_cnt) >= GAP);
        hund_zero = (disp_h == 4'd0) && !disp_ovf;
        digit     = disp_o;
        onehot    = 3'b001;
        blank     = 1'b0;
        case (la_slot)
            SLOT_TENS: begin
                digit  = disp_t;
                onehot = 3'b010;
                blank  = (LZB != 0) && hund_zero && (disp_t == 4'd0);
            end
            SLOT_HUND: begin
                digit  = disp_h;
                onehot = 3'b100;
                blank  = (LZB != 0) && hund_zero;
            end
            default: begin
                digit  = disp_o;
                onehot = 3'b001;
                blank  = 1'b0;
            end
        endcase
        show     = la_active && !blank;
        seg_d    = show ? bcd_to_seg(digit) : SEG_BLANK;
        dig_en_d = show ? onehot : '0;
        dp_d     = la_active && (la_slot == SLOT_HUND) && disp_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp         <= dp_d;
            dig_en     <= dig_en_d;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: per-cycle comparison against a frame-arithmetic model.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] h_in = '0, t_in = '0, o_in = '0;
    logic       ovf_in = 1'b0;
    logic       ready, dp, frame_done;
    logic [6:0] seg;
    logic [2:0] dig_en;

    int errors = 0;
    int checks = 0;

    // Model: cyc = cycles since last reset; slot/cnt follow by plain division.
    int         cyc = 0;
    logic [3:0] m_disp [3];
    logic       m_dovf;
    logic [3:0] m_pend [3];
    logic       m_povf;
    bit         m_full;
    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
    logic [12:0] obs, expv;

    localparam logic [12:0] RESET_VEC = 13'b0000000_0_000_0_1;

    seg7_scan_driver #(.CLK_DIV(8), .GAP(2), .LZB(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .hundreds   (h_in),
        .tens       (t_in),
        .ones       (o_in),
        .ovf        (ovf_in),
        .ready      (ready),
        .seg        (seg),
        .dp         (dp),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] model_out();
        int c = cyc % 8;
        int s = (cyc / 8) % 3;
        logic [6:0] sg = '0;
        logic [2:0] en = '0;
        logic d = 1'b0;
        bit blank;
        if (c >= 2) begin
            blank = (s == 2 && m_disp[2] == 0 && !m_dovf) ||
                    (s == 1 && m_disp[2] == 0 && m_disp[1] == 0 && !m_dovf);
            if (!blank) begin
                en = 3'(1 << s);
                sg = seg_tab[m_disp[s]];
            end
            d = (s == 2) && m_dovf;
        end
        return {sg, d, en, (cyc > 0 && cyc % 24 == 0), !m_full};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            cyc = 0;
            for (int i = 0; i < 3; i++) begin m_disp[i] = '0; m_pend[i] = '0; end
            m_dovf = 1'b0; m_povf = 1'b0; m_full = 1'b0;
        end else begin
            if (cyc % 24 == 23 && m_full) begin
                for (int i = 0; i < 3; i++) m_disp[i] = m_pend[i];
                m_dovf = m_povf;
                m_full = 1'b0;
            end else if (load && !m_full) begin
                m_pend[0] = o_in; m_pend[1] = t_in; m_pend[2] = h_in;
                m_povf = ovf_in;
                m_full = 1'b1;
            end
            cyc++;
        end
        #1;
        obs  = {seg, dp, dig_en, frame_done, ready};
        expv = model_out();
    endtask

    task automatic go_phase(input int p);
        for (int i = 0; i < 24 && (cyc % 24) != p; i++) tick();
    endtask

    task automatic set_in(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o, input logic v);
        h_in = h; t_in = t; o_in = o; ovf_in = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_hold got=%b want=%b", obs, RESET_VEC);
            end
        end
        rst = 1'b0;
        repeat (48) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_scan cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_digits();
        int pulses = 0;
        go_phase(0);
        set_in(4'd1, 4'd2, 4'd8, 1'b0);
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL digits_ready_drop got=%b want=0", ready);
        end
        repeat (60) begin
            tick();
            pulses += int'(frame_done);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL digits cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL digits_frame_done got=%0d pulses want=2", pulses);
        end
    endtask

    task automatic test_lzb();
        logic [3:0] vals [2][3] = '{'{4'd0, 4'd0, 4'd7}, '{4'd0, 4'd5, 4'd0}};
        for (int k = 0; k < 2; k++) begin
            go_phase(0);
            set_in(vals[k][0], vals[k][1], vals[k][2], 1'b0);
            load = 1'b1;
            tick();
            load = 1'b0;
            repeat (50) begin
                tick();
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL lzb%0d cyc=%0d got=%b want=%b", k, cyc, obs, expv);
                end
            end
        end
    endtask

    task automatic test_overflow();
        go_phase(0);
        set_in(4'd0, 4'd4, 4'd4, 1'b1);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (50) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL overflow cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_ignored_load();
        go_phase(0);
        set_in(4'd1, 4'd2, 4'd8, 1'b0);
        load = 1'b1;
        tick();
        set_in(4'd9, 4'd9, 4'd9, 1'b1);
        repeat (5) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL ignored_load cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        load = 1'b0;
        go_phase(0);
        set_in(4'd0, 4'd0, 4'hC, 1'b0);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (70) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL illegal_code cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_boundary_load();
        go_phase(23);
        set_in(4'd3, 4'd6, 4'd9, 1'b0);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (60) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL boundary_load cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_mid_reset();
        go_phase(4);
        set_in(4'd5, 4'd5, 4'd5, 1'b1);
        load = 1'b1;
        tick();
        load = 1'b0;
        go_phase(12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset got=%b want=%b", obs, RESET_VEC);
        end
        repeat (60) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL after_reset cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        repeat (720) begin
            set_in(4'($urandom_range(15)), 4'($urandom_range(15)),
                   4'($urandom_range(15)), 1'($urandom_range(1)));
            load = ($urandom_range(5) == 0);
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_lzb();
        test_overflow();
        test_ignored_load();
        test_boundary_load();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
